imem_responder: RTL and testbench

Instruction-memory responder on the fetch interface. It receives fetch addresses and returns instruction words on a registered 1-cycle read path, and flags address exceptions. After reset it zero-clears its storage, then accepts a program image over a word-streaming load port, then serves fetches. It sits between the fetch stage and the board/testbench program source.

---
 rtl/imem_responder_pkg.sv | 43 ++++
 rtl/imem_responder_if.sv | 45 ++++
 rtl/imem_responder_ram.sv | 55 +++++
 rtl/imem_responder.sv | 108 ++++++++++
 tb/tb_imem_responder.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_responder_pkg.sv
// Shared constants, types and address helpers for the instruction-memory responder.
// Optional IMEM_PARITY_EN adds an even-parity bit to every stored word.
package imem_responder_pkg;

  localparam int unsigned DEPTH_WORDS = 4096;
  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam int unsigned DW          = 32;

  localparam logic [31:0] BASE_ADDR = 32'h0000_3000;
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS) - 32'd4;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_NONE = 5'd0;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

`ifdef IMEM_PARITY_EN
  typedef struct packed {
    logic          par;
    logic [DW-1:0] data;
  } ram_word_t;
`else
  typedef struct packed {
    logic [DW-1:0] data;
  } ram_word_t;
`endif

  // Misaligned or outside the mapped window.
  function automatic logic addr_illegal(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || (addr > LAST_ADDR);
  endfunction

  function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch and program-load signal bundle between the responder and its sources.
// Optional IMEM_PARITY_EN adds par_inject and o_parity_err.
interface imem_responder_if;

  logic        i_inst_req;
  logic [31:0] i_inst_addr;
  logic        i_inst_ready;
  logic        o_inst_rvalid;
  logic [31:0] i_inst_rdata;
  logic [4:0]  o_inst_exc;

  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;

`ifdef IMEM_PARITY_EN
  logic        par_inject;
  logic        o_parity_err;

  modport master (
    output i_inst_req, i_inst_addr, load_valid, load_data, load_last, par_inject,
    input  i_inst_ready, o_inst_rvalid, i_inst_rdata, o_inst_exc,
           load_ready, load_done, o_parity_err
  );
  modport slave (
    input  i_inst_req, i_inst_addr, load_valid, load_data, load_last, par_inject,
    output i_inst_ready, o_inst_rvalid, i_inst_rdata, o_inst_exc,
           load_ready, load_done, o_parity_err
  );
`else
  modport master (
    output i_inst_req, i_inst_addr, load_valid, load_data, load_last,
    input  i_inst_ready, o_inst_rvalid, i_inst_rdata, o_inst_exc,
           load_ready, load_done
  );
  modport slave (
    input  i_inst_req, i_inst_addr, load_valid, load_data, load_last,
    output i_inst_ready, o_inst_rvalid, i_inst_rdata, o_inst_exc,
           load_ready, load_done
  );
`endif

endinterface

// File: rtl/imem_responder_ram.sv
// imem_ram: single-port array, synchronous write, registered read with synchronous zeroing.
// With IMEM_PARITY_EN a failing parity check zeroes the data and flags perr.
module imem_ram
  import imem_responder_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  ram_word_t     wdata,
  input  logic          re,
  input  logic          rclr,
`ifdef IMEM_PARITY_EN
  output logic          perr,
`endif
  output logic [DW-1:0] rdata
);

  ram_word_t mem [DEPTH_WORDS];
  ram_word_t rd_word;

  assign rd_word = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register holds its value between requests; rclr returns zero for faulting fetches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
`ifdef IMEM_PARITY_EN
      perr  <= 1'b0;
`endif
    end else if (rclr) begin
      rdata <= '0;
`ifdef IMEM_PARITY_EN
      perr  <= 1'b0;
`endif
    end else if (re) begin
`ifdef IMEM_PARITY_EN
      if (^rd_word) begin
        rdata <= '0;
        perr  <= 1'b1;
      end else begin
        rdata <= rd_word.data;
        perr  <= 1'b0;
      end
`else
      rdata <= rd_word.data;
`endif
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: clears storage, loads a streamed image, then serves fetches.
// Optional IMEM_PARITY_EN stores per-word even parity and reports mismatches.
module imem_responder
  import imem_responder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  imem_responder_if.slave    bus
);

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic [AW-1:0] ld_ptr;

  logic          fetch_acc;
  logic          fetch_bad;
  logic          load_acc;
  logic          ram_we;
  logic          ram_re;
  logic          ram_rclr;
  logic [AW-1:0] ram_addr;
  ram_word_t     ram_wdata;

  assign fetch_acc = bus.i_inst_req & bus.i_inst_ready;
  assign fetch_bad = addr_illegal(bus.i_inst_addr);
  assign load_acc  = bus.load_valid & bus.load_ready;

  // Single RAM port: writes during CLEAR/LOAD, reads during SERVE.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_rclr  = 1'b0;
    ram_addr  = word_index(bus.i_inst_addr);
    ram_wdata = '0;
    case (state)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_ptr;
      end
      ST_LOAD: begin
        ram_we         = load_acc;
        ram_addr       = ld_ptr;
        ram_wdata.data = bus.load_data;
`ifdef IMEM_PARITY_EN
        ram_wdata.par  = (^bus.load_data) ^ bus.par_inject;
`endif
      end
      default: begin
        ram_re   = fetch_acc & ~fetch_bad;
        ram_rclr = fetch_acc & fetch_bad;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= ST_CLEAR;
      clr_ptr           <= '0;
      ld_ptr            <= '0;
      bus.load_ready    <= 1'b0;
      bus.load_done     <= 1'b0;
      bus.i_inst_ready  <= 1'b0;
      bus.o_inst_rvalid <= 1'b0;
      bus.o_inst_exc    <= EXC_NONE;
    end else begin
      bus.o_inst_rvalid <= fetch_acc;
      if (fetch_acc) bus.o_inst_exc <= fetch_bad ? EXC_ADEL : EXC_NONE;
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == AW'(DEPTH_WORDS - 1)) begin
            state          <= ST_LOAD;
            ld_ptr         <= '0;
            bus.load_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_acc) begin
            ld_ptr <= ld_ptr + AW'(1);
            // Filling the last index ends the load; the pointer never wraps.
            if (bus.load_last || (ld_ptr == AW'(DEPTH_WORDS - 1))) begin
              state            <= ST_SERVE;
              bus.load_ready   <= 1'b0;
              bus.load_done    <= 1'b1;
              bus.i_inst_ready <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  imem_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .rclr  (ram_rclr),
`ifdef IMEM_PARITY_EN
    .perr  (bus.o_parity_err),
`endif
    .rdata (bus.i_inst_rdata)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder against a word-array reference model.
// Parity scenario is compiled when IMEM_PARITY_EN is defined.
module tb_imem_responder;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  imem_responder_if bus ();

  imem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_mem [4096];
  logic [31:0] last_rdata;
  logic [4:0]  last_exc;
  logic [37:0] got;
  logic [37:0] exp;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  // Reference behaviour: window is 0x3000..0x6ffc, word aligned.
  function automatic bit m_illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a >= 32'h7000);
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] a);
    logic [31:0] idx;
    if (m_illegal(a)) return 32'h0;
    idx = (a - 32'h3000) / 4;
    return model_mem[idx[11:0]];
  endfunction

  task automatic idle_inputs();
    bus.i_inst_req  = 1'b0;
    bus.i_inst_addr = 32'h0;
    bus.load_valid  = 1'b0;
    bus.load_data   = 32'h0;
    bus.load_last   = 1'b0;
`ifdef IMEM_PARITY_EN
    bus.par_inject  = 1'b0;
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) model_mem[i] = 32'h0;
    last_rdata = 32'h0;
    last_exc   = 5'd0;
  endtask

  // Pulse reset, release it and count edges until load_ready rises.
  task automatic reset_and_clear(output int cycles);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
    cycles = 0;
    while (bus.load_ready !== 1'b1 && cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic load_word(input logic [31:0] data, input bit last, input bit inject);
    int n;
    n = 0;
    while (bus.load_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      vectors++; miscompares++;
      $display("FAIL load_ready_timeout: load_ready=%b, required 1", bus.load_ready);
    end
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    bus.load_last  = last;
`ifdef IMEM_PARITY_EN
    bus.par_inject = inject;
`else
    if (inject) $display("note: parity injection requested without parity build");
`endif
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
`ifdef IMEM_PARITY_EN
    bus.par_inject = 1'b0;
`endif
  endtask

  // One fetch cycle; returns with the response visible.
  task automatic fetch(input logic [31:0] addr);
    bus.i_inst_req  = 1'b1;
    bus.i_inst_addr = addr;
    @(posedge clk); #1;
    bus.i_inst_req  = 1'b0;
  endtask

  task automatic test_reset();
    int  cycles;
    bit  leaked;
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    got = 38'h0;
    vectors++;
    if ({bus.i_inst_ready, bus.o_inst_rvalid, bus.i_inst_rdata, bus.o_inst_exc,
         bus.load_ready, bus.load_done} !== 41'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0",
               {bus.i_inst_ready, bus.o_inst_rvalid, bus.i_inst_rdata, bus.o_inst_exc,
                bus.load_ready, bus.load_done});
    end
    model_clear();
    reset = 1'b1;
    bus.i_inst_req  = 1'b1;
    bus.i_inst_addr = 32'h3000;
    cycles = 0;
    leaked = 1'b0;
    while (bus.load_ready !== 1'b1 && cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.o_inst_rvalid !== 1'b0 || bus.i_inst_ready !== 1'b0) leaked = 1'b1;
    end
    bus.i_inst_req = 1'b0;
    vectors++;
    if (cycles !== 4096) begin
      miscompares++;
      $display("FAIL clear_length: load_ready after %0d cycles, required 4096", cycles);
    end
    vectors++;
    if (leaked !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_during_clear: ready/rvalid seen=%b, required 0", leaked);
    end
    vectors++;
    if ({bus.load_done, bus.i_inst_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL load_state_flags: done,ready=%b, required 00",
               {bus.load_done, bus.i_inst_ready});
    end
  endtask

  task automatic test_small_load();
    logic [31:0] words [3];
    logic [31:0] addrs [4];
    words[0] = 32'h2401_0001; words[1] = 32'h2402_0002; words[2] = 32'h0022_1820;
    for (int i = 0; i < 3; i++) begin
      load_word(words[i], i == 2, 1'b0);
      model_mem[i] = words[i];
    end
    vectors++;
    if ({bus.load_done, bus.load_ready, bus.i_inst_ready} !== 3'b101) begin
      miscompares++;
      $display("FAIL serve_entry: done,load_ready,ready=%b, required 101",
               {bus.load_done, bus.load_ready, bus.i_inst_ready});
    end
    addrs[0] = 32'h3000; addrs[1] = 32'h3004; addrs[2] = 32'h3008; addrs[3] = 32'h300c;
    for (int i = 0; i < 4; i++) begin
      fetch(addrs[i]);
      got = {bus.o_inst_rvalid, bus.o_inst_exc, bus.i_inst_rdata};
      exp = {1'b1, 5'd0, m_data(addrs[i])};
      last_rdata = m_data(addrs[i]); last_exc = 5'd0;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h, required %h", i, got, exp);
      end
    end
  endtask

  task automatic test_exceptions();
    logic [31:0] addrs [7];
    addrs[0] = 32'h3002; addrs[1] = 32'h2ffc; addrs[2] = 32'h7000; addrs[3] = 32'h6ffc;
    addrs[4] = 32'h3001; addrs[5] = 32'hffff_fffc; addrs[6] = 32'h0;
    for (int i = 0; i < 7; i++) begin
      fetch(addrs[i]);
      last_rdata = m_data(addrs[i]);
      last_exc   = m_illegal(addrs[i]) ? 5'd4 : 5'd0;
      got = {bus.o_inst_rvalid, bus.o_inst_exc, bus.i_inst_rdata};
      exp = {1'b1, last_exc, last_rdata};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL exception[%h]: got %h, required %h", addrs[i], got, exp);
      end
    end
    fetch(32'h3004);
    last_rdata = m_data(32'h3004); last_exc = 5'd0;
    fetch(32'h3003);
    last_rdata = 32'h0; last_exc = 5'd4;
    @(posedge clk); #1;
    got = {bus.o_inst_rvalid, bus.o_inst_exc, bus.i_inst_rdata};
    exp = {1'b0, last_exc, last_rdata};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL idle_hold: got %h, required %h", got, exp);
    end
  endtask

  // Random request pattern with idle gaps; idle cycles must hold the previous response.
  task automatic test_random_fetch(input int n);
    logic [31:0] a;
    bit          req;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
        1:       a = 32'h3000 + 32'($urandom_range(0, 16383));
        2:       a = ($urandom_range(0, 1) == 0 ? 32'h2ff0 : 32'h6ff0) + 32'($urandom_range(0, 31));
        default: a = $urandom;
      endcase
      req = ($urandom_range(0, 3) != 0);
      bus.i_inst_req  = req;
      bus.i_inst_addr = a;
      @(posedge clk); #1;
      bus.i_inst_req = 1'b0;
      if (req) begin
        last_rdata = m_data(a);
        last_exc   = m_illegal(a) ? 5'd4 : 5'd0;
      end
      got = {bus.o_inst_rvalid, bus.o_inst_exc, bus.i_inst_rdata};
      exp = {req, last_exc, last_rdata};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random_fetch[%0d] addr=%h: got %h, required %h", i, a, got, exp);
      end
    end
  endtask

  task automatic test_full_load();
    int          cycles;
    logic [31:0] w;
    reset_and_clear(cycles);
    vectors++;
    if (cycles !== 4096) begin
      miscompares++;
      $display("FAIL full_clear_length: %0d cycles, required 4096", cycles);
    end
    for (int i = 0; i < 4096; i++) begin
      w = $urandom;
      model_mem[i] = w;
      bus.load_valid = 1'b1;
      bus.load_data  = w;
      bus.load_last  = 1'b0;
      @(posedge clk); #1;
      if (i == 4094) begin
        vectors++;
        if (bus.load_done !== 1'b0) begin
          miscompares++;
          $display("FAIL early_serve: load_done=%b after 4095 words, required 0", bus.load_done);
        end
      end
    end
    bus.load_valid = 1'b0;
    vectors++;
    if ({bus.load_done, bus.load_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL full_serve_entry: done,load_ready=%b, required 10",
               {bus.load_done, bus.load_ready});
    end
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hdead_beef;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    vectors++;
    if ({bus.load_done, bus.load_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL extra_word: done,load_ready=%b, required 10",
               {bus.load_done, bus.load_ready});
    end
    fetch(32'h6ffc);
    last_rdata = model_mem[4095]; last_exc = 5'd0;
    got = {bus.o_inst_rvalid, bus.o_inst_exc, bus.i_inst_rdata};
    exp = {1'b1, 5'd0, model_mem[4095]};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL last_word: got %h, required %h", got, exp);
    end
    fetch(32'h3000);
    last_rdata = model_mem[0];
    got = {bus.o_inst_rvalid, bus.o_inst_exc, bus.i_inst_rdata};
    exp = {1'b1, 5'd0, model_mem[0]};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL first_word: got %h, required %h", got, exp);
    end
    test_random_fetch(300);
  endtask

  task automatic test_reset_mid_load();
    int cycles;
    reset_and_clear(cycles);
    load_word(32'h1111_1111, 1'b0, 1'b0);
    load_word(32'h2222_2222, 1'b0, 1'b0);
    vectors++;
    if (bus.load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_load_ready: load_ready=%b, required 1", bus.load_ready);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({bus.i_inst_ready, bus.o_inst_rvalid, bus.i_inst_rdata, bus.o_inst_exc,
         bus.load_ready, bus.load_done} !== 41'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h, required 0",
               {bus.i_inst_ready, bus.o_inst_rvalid, bus.i_inst_rdata, bus.o_inst_exc,
                bus.load_ready, bus.load_done});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
    cycles = 0;
    while (bus.load_ready !== 1'b1 && cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
    end
    vectors++;
    if (cycles !== 4096) begin
      miscompares++;
      $display("FAIL reclear_length: %0d cycles, required 4096", cycles);
    end
    load_word(32'habcd_0123, 1'b1, 1'b0);
    model_mem[0] = 32'habcd_0123;
    fetch(32'h3004);
    got = {bus.o_inst_rvalid, bus.o_inst_exc, bus.i_inst_rdata};
    exp = {1'b1, 5'd0, m_data(32'h3004)};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL stale_word: got %h, required %h", got, exp);
    end
    fetch(32'h3000);
    got = {bus.o_inst_rvalid, bus.o_inst_exc, bus.i_inst_rdata};
    exp = {1'b1, 5'd0, m_data(32'h3000)};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reloaded_word: got %h, required %h", got, exp);
    end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    int cycles;
    reset_and_clear(cycles);
    load_word(32'h1234_5678, 1'b0, 1'b1);
    load_word(32'h9abc_def0, 1'b1, 1'b0);
    fetch(32'h3000);
    got = {bus.o_parity_err, bus.o_inst_exc, bus.i_inst_rdata};
    exp = {1'b1, 5'd0, 32'h0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL parity_error: got %h, required %h", got, exp);
    end
    fetch(32'h3004);
    got = {bus.o_parity_err, bus.o_inst_exc, bus.i_inst_rdata};
    exp = {1'b0, 5'd0, 32'h9abc_def0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL parity_clean: got %h, required %h", got, exp);
    end
    fetch(32'h3008);
    got = {bus.o_parity_err, bus.o_inst_exc, bus.i_inst_rdata};
    exp = {1'b0, 5'd0, 32'h0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL parity_cleared_word: got %h, required %h", got, exp);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_small_load();
    test_exceptions();
    test_random_fetch(200);
    test_full_load();
    test_reset_mid_load();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
